// File: rtl/uart_tx_frame_engine.sv
// UART transmit engine: start / data (LSB first) / optional parity / 1-2 stop bits, config latched per frame.
// Define UART_TX_HOLD_EN to add a one-entry holding register for gap-free back-to-back frames.
module uart_tx_frame_engine #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      DATA_VALID,
    output logic                      DATA_READY,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    input  logic                      STOP2,
    input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
    output logic                      TX_OUT,
    output logic                      BUSY
);
    localparam int BIT_W = $clog2(DATA_WIDTH);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP1  = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    state_t                    r_state;
    logic [DATA_WIDTH-1:0]     r_shift;
    logic                      r_par_bit;
    logic                      r_par_en;
    logic                      r_stop2;
    logic                      r_tx;
    logic [PRESCALE_WIDTH-1:0] r_last_cnt;
    logic [PRESCALE_WIDTH-1:0] r_cnt;
    logic [BIT_W-1:0]          r_bit_idx;

    logic                      w_transfer;
    logic                      w_bit_end;
    logic                      w_load;
    logic [DATA_WIDTH-1:0]     w_src_data;
    logic                      w_src_par_en;
    logic                      w_src_par_typ;
    logic                      w_src_stop2;
    logic [PRESCALE_WIDTH-1:0] w_src_presc;

    assign w_transfer = DATA_VALID && DATA_READY;
    assign w_bit_end  = (r_cnt == r_last_cnt);

`ifdef UART_TX_HOLD_EN
    logic                      r_hold_full;
    logic [DATA_WIDTH-1:0]     r_hold_data;
    logic                      r_hold_par_en;
    logic                      r_hold_par_typ;
    logic                      r_hold_stop2;
    logic [PRESCALE_WIDTH-1:0] r_hold_presc;
    logic                      w_frame_end;
    logic                      w_line_free;

    assign w_frame_end = w_bit_end && (((r_state == S_STOP1) && !r_stop2) || (r_state == S_STOP2));
    assign w_line_free = (r_state == S_IDLE) || w_frame_end;
    assign DATA_READY  = !r_hold_full;
    // A held frame always wins the line; otherwise a fresh transfer bypasses the hold.
    assign w_load        = w_line_free && (r_hold_full || w_transfer);
    assign w_src_data    = r_hold_full ? r_hold_data    : P_DATA;
    assign w_src_par_en  = r_hold_full ? r_hold_par_en  : PAR_EN;
    assign w_src_par_typ = r_hold_full ? r_hold_par_typ : PAR_TYP;
    assign w_src_stop2   = r_hold_full ? r_hold_stop2   : STOP2;
    assign w_src_presc   = r_hold_full ? r_hold_presc   : PRESCALE;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_hold_full    <= 1'b0;
            r_hold_data    <= '0;
            r_hold_par_en  <= 1'b0;
            r_hold_par_typ <= 1'b0;
            r_hold_stop2   <= 1'b0;
            r_hold_presc   <= '0;
        end else if (w_transfer && !w_line_free) begin
            r_hold_full    <= 1'b1;
            r_hold_data    <= P_DATA;
            r_hold_par_en  <= PAR_EN;
            r_hold_par_typ <= PAR_TYP;
            r_hold_stop2   <= STOP2;
            r_hold_presc   <= PRESCALE;
        end else if (w_load && r_hold_full) begin
            r_hold_full <= 1'b0;
        end
    end
`else
    assign DATA_READY    = (r_state == S_IDLE);
    assign w_load        = w_transfer;
    assign w_src_data    = P_DATA;
    assign w_src_par_en  = PAR_EN;
    assign w_src_par_typ = PAR_TYP;
    assign w_src_stop2   = STOP2;
    assign w_src_presc   = PRESCALE;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_state    <= S_IDLE;
            r_tx       <= 1'b1;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_par_bit  <= 1'b0;
            r_par_en   <= 1'b0;
            r_stop2    <= 1'b0;
            r_last_cnt <= '0;
        end else if (w_load) begin
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= w_src_data;
            r_par_bit  <= w_src_par_typ ? ~^w_src_data : ^w_src_data;
            r_par_en   <= w_src_par_en;
            r_stop2    <= w_src_stop2;
            // Prescale 0 behaves as 1 cycle per bit.
            r_last_cnt <= (w_src_presc == '0) ? '0 : w_src_presc - PRESCALE_WIDTH'(1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx      <= 1'b1;
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                end
                S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2: begin
                    if (!w_bit_end) begin
                        r_cnt <= r_cnt + PRESCALE_WIDTH'(1);
                    end else begin
                        r_cnt <= '0;
                        case (r_state)
                            S_START: begin
                                r_state <= S_DATA;
                                r_tx    <= r_shift[0];
                            end
                            S_DATA: begin
                                if (r_bit_idx == LAST_BIT) begin
                                    r_bit_idx <= '0;
                                    r_state   <= r_par_en ? S_PARITY : S_STOP1;
                                    r_tx      <= r_par_en ? r_par_bit : 1'b1;
                                end else begin
                                    r_bit_idx <= r_bit_idx + BIT_W'(1);
                                    r_shift   <= r_shift >> 1;
                                    r_tx      <= r_shift[1];
                                end
                            end
                            S_PARITY: begin
                                r_state <= S_STOP1;
                                r_tx    <= 1'b1;
                            end
                            S_STOP1: begin
                                r_state <= r_stop2 ? S_STOP2 : S_IDLE;
                                r_tx    <= 1'b1;
                            end
                            default: begin
                                r_state <= S_IDLE;
                                r_tx    <= 1'b1;
                            end
                        endcase
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_tx      <= 1'b1;
                    r_cnt     <= '0;
                    r_bit_idx <= '0;
                end
            endcase
        end
    end

    assign TX_OUT = r_tx;
    assign BUSY   = (r_state != S_IDLE);
endmodule

// File: tb/tb_uart_tx_frame_engine.sv
// Bench for uart_tx_frame_engine: per-cycle line model built from frame bit lists, directed and random frames.
module tb_uart_tx_frame_engine;
    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK        = 1'b0;
    logic          RST        = 1'b0;
    logic [DW-1:0] P_DATA     = '0;
    logic          DATA_VALID = 1'b0;
    logic          PAR_EN     = 1'b0;
    logic          PAR_TYP    = 1'b0;
    logic          STOP2      = 1'b0;
    logic [PW-1:0] PRESCALE   = '0;
    logic          DATA_READY;
    logic          TX_OUT;
    logic          BUSY;

    uart_tx_frame_engine #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .DATA_READY (DATA_READY),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .STOP2      (STOP2),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef bit bitq_t[$];

    bit    line_q[$];      // line level for each upcoming cycle of the current frame
    bitq_t held_bits;
    int    held_n     = 1;
    bit    held_valid = 1'b0;
    bit    armed      = 1'b0;

    function automatic bitq_t frame_bits(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2);
        bitq_t q;
        int ones = 0;
        q.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pe) q.push_back(pt ? ((ones % 2) == 0) : ((ones % 2) == 1));
        q.push_back(1'b1);
        if (s2) q.push_back(1'b1);
        return q;
    endfunction

    function automatic int eff_n(input logic [PW-1:0] ps);
        return (ps == '0) ? 1 : int'(ps);
    endfunction

    function automatic logic [15:0] pack(input bitq_t q);
        logic [15:0] v = '0;
        foreach (q[i]) if (i < 16) v[i] = q[i];
        return v;
    endfunction

    function automatic bit model_ready();
`ifdef UART_TX_HOLD_EN
        return !held_valid;
`else
        return line_q.size() == 0;
`endif
    endfunction

    task automatic load_line(input bitq_t b, input int n);
        foreach (b[j]) for (int k = 0; k < n; k++) line_q.push_back(b[j]);
    endtask

    always @(posedge CLK or negedge RST) begin : model
        bit acc;
        if (!RST) begin
            line_q.delete();
            held_valid = 1'b0;
        end else begin
            acc = (DATA_VALID === 1'b1) && model_ready();
            if (line_q.size() > 0) void'(line_q.pop_front());
            if (line_q.size() == 0) begin
                if (held_valid) begin
                    load_line(held_bits, held_n);
                    held_valid = 1'b0;
                end else if (acc) begin
                    load_line(frame_bits(P_DATA, PAR_EN, PAR_TYP, STOP2), eff_n(PRESCALE));
                end
            end else if (acc) begin
                held_bits  = frame_bits(P_DATA, PAR_EN, PAR_TYP, STOP2);
                held_n     = eff_n(PRESCALE);
                held_valid = 1'b1;
            end
        end
    end

    always @(negedge CLK) begin
        if (armed && RST === 1'b1) begin
            check("tx_out",     TX_OUT,     (line_q.size() > 0) ? line_q[0] : 1'b1);
            check("busy",       BUSY,       line_q.size() > 0);
            check("data_ready", DATA_READY, model_ready());
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2, input logic [PW-1:0] ps);
        int waited = 0;
        bit done   = 1'b0;
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; PRESCALE = ps; DATA_VALID = 1'b1;
        while (!done) begin
            @(negedge CLK);
            if (DATA_READY === 1'b1) begin
                @(posedge CLK);
                #1 DATA_VALID = 1'b0;
                done = 1'b1;
            end else begin
                waited++;
                if (waited > 300) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL send_timeout: DATA_READY=%b after %0d cycles, expected 1", DATA_READY, waited);
                    DATA_VALID = 1'b0;
                    done = 1'b1;
                end
            end
        end
        $display("sent data=0x%02h par_en=%0b par_typ=%0b stop2=%0b prescale=%0d at t=%0t", d, pe, pt, s2, ps, $time);
    endtask

    // Called just after the accepting edge: samples one level per cycle until BUSY drops.
    task automatic capture(input int n, output logic [15:0] bits, output int busy_n);
        bit tr[$];
        int c    = 0;
        bit done = 1'b0;
        bits = '0;
        while (!done) begin
            @(negedge CLK);
            if (BUSY !== 1'b1) begin
                done = 1'b1;
            end else begin
                tr.push_back(TX_OUT);
                c++;
                if (c >= 1000) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL capture_timeout: BUSY still 1 after %0d cycles, expected 0", c);
                    done = 1'b1;
                end
            end
        end
        busy_n = c;
        for (int j = 0; j < 16; j++) if (j * n < tr.size()) bits[j] = tr[j * n];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- test sequence ----------------
    initial begin
        logic [15:0] bits;
        int          busy_n;
        bit          busy_tr[60];
        bit          ready_tr[60];
        int          first_zero;
        int          busy_total;
        int          guard;

        repeat (3) @(negedge CLK);
        #2 RST = 1'b1;
        armed = 1'b1;

        repeat (20) @(negedge CLK);
        check("idle_tx", TX_OUT, 1);
        check("idle_busy", BUSY, 0);
        check("idle_ready", DATA_READY, 1);

        check("model_a5", pack(frame_bits(8'hA5, 0, 0, 0)), 16'h034A);
        check("model_par_even", pack(frame_bits(8'h07, 1, 0, 0)), 16'h060E);
        check("model_par_odd", pack(frame_bits(8'h07, 1, 1, 0)), 16'h040E);

        send(8'hA5, 0, 0, 0, 4);
        capture(4, bits, busy_n);
        check("a5_line", bits, 16'h034A);
        check("a5_len", busy_n, 40);

        send(8'h07, 1, 0, 0, 1);
        capture(1, bits, busy_n);
        check("par_even_line", bits, 16'h060E);
        check("par_even_len", busy_n, 11);

        send(8'h07, 1, 1, 0, 1);
        capture(1, bits, busy_n);
        check("par_odd_line", bits, 16'h040E);
        check("par_odd_len", busy_n, 11);

        send(8'h07, 1, 0, 1, 1);
        capture(1, bits, busy_n);
        check("stop2_line", bits, 16'h0E0E);
        check("stop2_len", busy_n, 12);

        // Inputs changed mid-frame must not disturb the frame on the line.
        send(8'h3C, 1, 0, 0, 3);
        fork
            capture(3, bits, busy_n);
            begin
                repeat (5) @(negedge CLK);
                P_DATA = 8'hFF; PRESCALE = '0; PAR_EN = 1'b0;
            end
        join
        check("midchg_line", bits, 16'h0478);
        check("midchg_len", busy_n, 33);

        send(8'hFF, 0, 0, 0, 0);
        capture(1, bits, busy_n);
        check("presc0_line", bits, 16'h03FE);
        check("presc0_len", busy_n, 10);

        // Back-to-back: second frame offered during the first frame's data bits.
        send(8'h55, 0, 0, 0, 2);
        fork
            begin
                repeat (6) @(negedge CLK);
                send(8'h33, 0, 0, 0, 2);
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(negedge CLK);
                    busy_tr[c]  = BUSY;
                    ready_tr[c] = DATA_READY;
                end
            end
        join
        first_zero = -1;
        busy_total = 0;
        for (int c = 0; c < 60; c++) begin
            if (busy_tr[c]) busy_total++;
            else if (first_zero < 0) first_zero = c;
        end
        check("b2b_busy_total", busy_total, 40);
`ifdef UART_TX_HOLD_EN
        check("b2b_first_idle", first_zero, 40);
`else
        check("b2b_first_idle", first_zero, 20);
        check("b2b_gap_one", busy_tr[21], 1);
`endif
        check("b2b_ready_mid", ready_tr[10], 0);
        check("b2b_ready_c20", ready_tr[20], 1);

        // Reset during data bit 3.
        send(8'hC3, 0, 0, 0, 4);
        repeat (17) @(negedge CLK);
        check("pre_rst_tx", TX_OUT, 0);
        check("pre_rst_busy", BUSY, 1);
        #2 RST = 1'b0;
        #1;
        check("rst_tx_async", TX_OUT, 1);
        check("rst_busy", BUSY, 0);
        check("rst_ready", DATA_READY, 1);
        @(negedge CLK);
        #2 RST = 1'b1;
        repeat (20) @(negedge CLK);
        check("post_rst_tx", TX_OUT, 1);
        check("post_rst_busy", BUSY, 0);

        // Randomized frames with junk input changes while each frame is on the line.
        for (int t = 0; t < 40; t++) begin
            logic [DW-1:0] d;
            logic [PW-1:0] ps;
            bit            pe, pt, s2;
            d  = DW'($urandom);
            ps = PW'($urandom_range(0, 4));
            pe = $urandom_range(0, 1) != 0;
            pt = $urandom_range(0, 1) != 0;
            s2 = $urandom_range(0, 1) != 0;
            repeat ($urandom_range(0, 3)) @(negedge CLK);
            send(d, pe, pt, s2, ps);
            P_DATA   = DW'($urandom);
            PAR_EN   = $urandom_range(0, 1) != 0;
            PAR_TYP  = $urandom_range(0, 1) != 0;
            STOP2    = $urandom_range(0, 1) != 0;
            PRESCALE = PW'($urandom_range(0, 7));
        end

        guard = 0;
        while (BUSY === 1'b1 && guard < 500) begin
            @(negedge CLK);
            guard++;
        end
        check("final_idle_busy", BUSY, 0);
        repeat (5) @(negedge CLK);
        check("final_idle_tx", TX_OUT, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
